// File: rtl/mem_wb_pipe_stage_if.sv
// -----------------------------------------------------------------------------
// mem_wb_pipe_stage_if
//   Valid/ready bundle for one MEM->WB pipeline entry. It carries the control
//   bits, the destination register and the data payload.
//   master : drives valid/ctrl/waddr/data and samples ready
//   slave  : samples valid/ctrl/waddr/data and drives ready
// Parameters: DATA_W (data payload), CTRL_W (control bits), ADDR_W (write address)
// -----------------------------------------------------------------------------
interface mem_wb_pipe_stage_if #(
   parameter int DATA_W = 96,
   parameter int CTRL_W = 11,
   parameter int ADDR_W = 5
);
   logic              valid;
   logic              ready;
   logic [CTRL_W-1:0] ctrl;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] data;

   modport master (output valid, output ctrl, output waddr, output data, input ready);
   modport slave  (input valid, input ctrl, input waddr, input data, output ready);
endinterface

// File: rtl/mem_wb_pipe_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_pipe_stage
//   MEM->WB pipeline register with a 2-entry skid buffer. Because of the skid
//   buffer, in_if.ready can be a plain flop with no combinational path from
//   in_if.valid or out_if.ready. Control bits read zero whenever no entry is
//   presented, so a bubble or a flushed instruction can never write the
//   register file or HI/LO.
// Ports:
//   clock_i      rising-edge clock
//   reset_ni     asynchronous active-low reset
//   flush_i      synchronous kill of every held entry and of the same-cycle accept
//   in_if        upstream entry (slave modport)
//   out_if       head entry towards write-back (master modport)
//   stall_cnt_o  saturating count of cycles with out valid && !out ready
//   bubble_cnt_o saturating count of cycles with !out valid
// Optional feature: define MEM_WB_STATS_EN to build the two statistics counters
// and their ports. Without it, both ports and the CNT_W parameter are absent.
// -----------------------------------------------------------------------------
module mem_wb_pipe_stage #(
   parameter int DATA_W = 96,
   parameter int CTRL_W = 11,
   parameter int ADDR_W = 5
`ifdef MEM_WB_STATS_EN
   ,
   parameter int CNT_W  = 16
`endif
) (
   input  logic                clock_i,
   input  logic                reset_ni,
   input  logic                flush_i,
   mem_wb_pipe_stage_if.slave  in_if,
   mem_wb_pipe_stage_if.master out_if
`ifdef MEM_WB_STATS_EN
   ,
   output logic [CNT_W-1:0]    stall_cnt_o,
   output logic [CNT_W-1:0]    bubble_cnt_o
`endif
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_BUSY  = 2'b01,
      ST_FULL  = 2'b10
   } state_t;

   state_t            state_q, state_d;
   logic              valid_q, valid_d;
   logic              ready_q, ready_d;
   logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
   logic [ADDR_W-1:0] main_waddr_q, main_waddr_d;
   logic [DATA_W-1:0] main_data_q,  main_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
   logic [ADDR_W-1:0] skid_waddr_q, skid_waddr_d;
   logic [DATA_W-1:0] skid_data_q,  skid_data_d;
   logic              acc_s;
   logic              pop_s;

   assign acc_s = in_if.valid && ready_q;
   assign pop_s = valid_q && out_if.ready;

   assign in_if.ready  = ready_q;
   assign out_if.valid = valid_q;
   assign out_if.ctrl  = main_ctrl_q;
   assign out_if.waddr = main_waddr_q;
   assign out_if.data  = main_data_q;

   // Next-state and next-entry logic; flush overrides every other event.
   always_comb begin
      state_d      = state_q;
      main_ctrl_d  = main_ctrl_q;
      main_waddr_d = main_waddr_q;
      main_data_d  = main_data_q;
      skid_ctrl_d  = skid_ctrl_q;
      skid_waddr_d = skid_waddr_q;
      skid_data_d  = skid_data_q;
      if (flush_i) begin
         // Zeroing ctrl is what makes a killed entry harmless; data is don't-care.
         state_d     = ST_EMPTY;
         main_ctrl_d = {CTRL_W{1'b0}};
         skid_ctrl_d = {CTRL_W{1'b0}};
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (acc_s) begin
                  main_ctrl_d  = in_if.ctrl;
                  main_waddr_d = in_if.waddr;
                  main_data_d  = in_if.data;
                  state_d      = ST_BUSY;
               end else begin
                  state_d = ST_EMPTY;
               end
            end
            ST_BUSY: begin
               if (acc_s && pop_s) begin
                  main_ctrl_d  = in_if.ctrl;
                  main_waddr_d = in_if.waddr;
                  main_data_d  = in_if.data;
               end else if (acc_s) begin
                  skid_ctrl_d  = in_if.ctrl;
                  skid_waddr_d = in_if.waddr;
                  skid_data_d  = in_if.data;
                  state_d      = ST_FULL;
               end else if (pop_s) begin
                  main_ctrl_d = {CTRL_W{1'b0}};
                  state_d     = ST_EMPTY;
               end else begin
                  state_d = ST_BUSY;
               end
            end
            ST_FULL: begin
               if (pop_s) begin
                  main_ctrl_d  = skid_ctrl_q;
                  main_waddr_d = skid_waddr_q;
                  main_data_d  = skid_data_q;
                  skid_ctrl_d  = {CTRL_W{1'b0}};
                  state_d      = ST_BUSY;
               end else begin
                  state_d = ST_FULL;
               end
            end
            default: begin
               state_d     = ST_EMPTY;
               main_ctrl_d = {CTRL_W{1'b0}};
               skid_ctrl_d = {CTRL_W{1'b0}};
            end
         endcase
      end
      // Handshake flags are decoded from the next state so both are pure flops.
      valid_d = (state_d != ST_EMPTY);
      ready_d = (state_d != ST_FULL);
   end

   // State, handshake flags and both entries.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q      <= ST_EMPTY;
         valid_q      <= 1'b0;
         ready_q      <= 1'b1;
         main_ctrl_q  <= {CTRL_W{1'b0}};
         main_waddr_q <= {ADDR_W{1'b0}};
         main_data_q  <= {DATA_W{1'b0}};
         skid_ctrl_q  <= {CTRL_W{1'b0}};
         skid_waddr_q <= {ADDR_W{1'b0}};
         skid_data_q  <= {DATA_W{1'b0}};
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         ready_q      <= ready_d;
         main_ctrl_q  <= main_ctrl_d;
         main_waddr_q <= main_waddr_d;
         main_data_q  <= main_data_d;
         skid_ctrl_q  <= skid_ctrl_d;
         skid_waddr_q <= skid_waddr_d;
         skid_data_q  <= skid_data_d;
      end
   end

`ifdef MEM_WB_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] bubble_cnt_q;

   assign stall_cnt_o  = stall_cnt_q;
   assign bubble_cnt_o = bubble_cnt_q;

   // Saturating statistics counters; only reset clears them, flush does not.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         stall_cnt_q  <= {CNT_W{1'b0}};
         bubble_cnt_q <= {CNT_W{1'b0}};
      end else begin
         if (valid_q && !out_if.ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_ONE;
         end
         if (!valid_q && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_q <= bubble_cnt_q + CNT_ONE;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
module tb_mem_wb_pipe_stage;
   localparam int DW = 96;
   localparam int CW = 11;
   localparam int AW = 5;
   localparam int NW = 8;

   typedef struct packed {
      logic [CW-1:0] ctrl;
      logic [AW-1:0] waddr;
      logic [DW-1:0] data;
   } ent_t;

   logic clk;
   logic rst_n;
   logic flush;
   int   n_cmp;
   int   n_err;

   mem_wb_pipe_stage_if #(.DATA_W(DW), .CTRL_W(CW), .ADDR_W(AW)) up_if ();
   mem_wb_pipe_stage_if #(.DATA_W(DW), .CTRL_W(CW), .ADDR_W(AW)) dn_if ();

`ifdef MEM_WB_STATS_EN
   logic [NW-1:0] stall_cnt;
   logic [NW-1:0] bubble_cnt;
`endif

   mem_wb_pipe_stage #(
      .DATA_W(DW), .CTRL_W(CW), .ADDR_W(AW)
`ifdef MEM_WB_STATS_EN
      , .CNT_W(NW)
`endif
   ) dut (
      .clock_i  (clk),
      .reset_ni (rst_n),
      .flush_i  (flush),
      .in_if    (up_if),
      .out_if   (dn_if)
`ifdef MEM_WB_STATS_EN
      , .stall_cnt_o  (stall_cnt)
      , .bubble_cnt_o (bubble_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic v, input ent_t e);
      up_if.valid = v;
      up_if.ctrl  = e.ctrl;
      up_if.waddr = e.waddr;
      up_if.data  = e.data;
   endtask

   function automatic ent_t mk(input logic [CW-1:0] c, input logic [DW-1:0] d);
      ent_t e;
      e.ctrl  = c;
      e.waddr = AW'(d[4:0]);
      e.data  = d;
      return e;
   endfunction

   task automatic do_reset();
      ent_t z;
      z = '0;
      rst_n = 1'b0;
      flush = 1'b0;
      dn_if.ready = 1'b0;
      drive(1'b0, z);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (dn_if.valid !== 1'b0 || up_if.ready !== 1'b1 || dn_if.ctrl !== {CW{1'b0}}) begin
         n_err++;
         $display("FAIL reset_in: valid=%b ready=%b ctrl=%h required 0/1/0", dn_if.valid, up_if.ready, dn_if.ctrl);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if (dn_if.valid !== 1'b0 || up_if.ready !== 1'b1 || dn_if.ctrl !== {CW{1'b0}}) begin
            n_err++;
            $display("FAIL reset_idle[%0d]: valid=%b ready=%b ctrl=%h required 0/1/0", i, dn_if.valid, up_if.ready, dn_if.ctrl);
         end
      end
   endtask

   task automatic test_stream();
      ent_t z;
      z = '0;
      do_reset();
      dn_if.ready = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, mk(11'h001, DW'(i)));
         n_cmp++;
         if (up_if.ready !== 1'b1) begin
            n_err++;
            $display("FAIL stream_ready[%0d]: got %b required 1", i, up_if.ready);
         end
         @(posedge clk);
         @(negedge clk);
         n_cmp++;
         if (dn_if.valid !== 1'b1 || dn_if.data !== DW'(i) || dn_if.ctrl !== 11'h001) begin
            n_err++;
            $display("FAIL stream_out[%0d]: valid=%b data=%0h ctrl=%h required 1/%0h/001", i, dn_if.valid, dn_if.data, dn_if.ctrl, i);
         end
      end
      drive(1'b0, z);
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (dn_if.valid !== 1'b0 || dn_if.ctrl !== {CW{1'b0}}) begin
         n_err++;
         $display("FAIL stream_drain: valid=%b ctrl=%h required 0/0", dn_if.valid, dn_if.ctrl);
      end
   endtask

   // Leaves the stage FULL with a then b, out_ready low, in_valid low.
   task automatic fill_two(input ent_t a, input ent_t b);
      ent_t z;
      z = '0;
      dn_if.ready = 1'b0;
      @(negedge clk);
      drive(1'b1, a);
      @(posedge clk);
      @(negedge clk);
      drive(1'b1, b);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, z);
   endtask

   task automatic test_full();
      ent_t a, b;
      a = mk(11'h155, {32'hAAAA_0001, 32'h1111_2222, 32'h0000_000A});
      b = mk(11'h2AA, {32'hBBBB_0002, 32'h3333_4444, 32'h0000_000B});
      do_reset();
      fill_two(a, b);
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (up_if.ready !== 1'b0 || dn_if.valid !== 1'b1 || dn_if.data !== a.data || dn_if.ctrl !== a.ctrl || dn_if.waddr !== a.waddr) begin
            n_err++;
            $display("FAIL full_hold[%0d]: ready=%b valid=%b data=%h required 0/1/%h", i, up_if.ready, dn_if.valid, dn_if.data, a.data);
         end
         @(posedge clk);
         @(negedge clk);
      end
      dn_if.ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (up_if.ready !== 1'b1 || dn_if.valid !== 1'b1 || dn_if.data !== b.data || dn_if.ctrl !== b.ctrl || dn_if.waddr !== b.waddr) begin
         n_err++;
         $display("FAIL full_second: ready=%b valid=%b data=%h required 1/1/%h", up_if.ready, dn_if.valid, dn_if.data, b.data);
      end
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (dn_if.valid !== 1'b0 || dn_if.ctrl !== {CW{1'b0}}) begin
         n_err++;
         $display("FAIL full_drain: valid=%b ctrl=%h required 0/0", dn_if.valid, dn_if.ctrl);
      end
   endtask

   task automatic test_flush();
      ent_t a, b, c, z;
      a = mk(11'h7FF, DW'(96'h1));
      b = mk(11'h7FE, DW'(96'h2));
      c = mk(11'h7FD, DW'(96'h3));
      z = '0;
      do_reset();
      fill_two(a, b);
      drive(1'b1, c);
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      drive(1'b0, z);
      n_cmp++;
      if (dn_if.valid !== 1'b0 || dn_if.ctrl !== {CW{1'b0}} || up_if.ready !== 1'b1) begin
         n_err++;
         $display("FAIL flush_full: valid=%b ctrl=%h ready=%b required 0/0/1", dn_if.valid, dn_if.ctrl, up_if.ready);
      end
      // Flush from BUSY while an accept and a pop coincide: both are dropped.
      dn_if.ready = 1'b1;
      drive(1'b1, a);
      @(posedge clk);
      @(negedge clk);
      drive(1'b1, c);
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      drive(1'b0, z);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (dn_if.valid !== 1'b0 || dn_if.ctrl !== {CW{1'b0}}) begin
            n_err++;
            $display("FAIL flush_busy[%0d]: valid=%b ctrl=%h required 0/0", i, dn_if.valid, dn_if.ctrl);
         end
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      fill_two(mk(11'h123, {3{32'hDEAD_BEEF}}), mk(11'h321, {3{32'hCAFE_F00D}}));
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (dn_if.valid !== 1'b0 || dn_if.ctrl !== {CW{1'b0}} || dn_if.data !== {DW{1'b0}} ||
          dn_if.waddr !== {AW{1'b0}} || up_if.ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_mid: valid=%b ctrl=%h waddr=%h data=%h ready=%b required 0/0/0/0/1",
                  dn_if.valid, dn_if.ctrl, dn_if.waddr, dn_if.data, up_if.ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_random(input int cycles);
      ent_t mq[$];
      ent_t e, head;
      logic exp_valid, exp_ready, acc, pop;
      logic [CW-1:0] exp_ctrl;
      do_reset();
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         exp_valid = (mq.size() > 0);
         exp_ready = (mq.size() < 2);
         head = exp_valid ? mq[0] : '0;
         exp_ctrl = exp_valid ? head.ctrl : {CW{1'b0}};
         n_cmp++;
         if (dn_if.valid !== exp_valid || up_if.ready !== exp_ready || dn_if.ctrl !== exp_ctrl) begin
            n_err++;
            $display("FAIL random_hs[%0d]: valid=%b ready=%b ctrl=%h required %b/%b/%h",
                     i, dn_if.valid, up_if.ready, dn_if.ctrl, exp_valid, exp_ready, exp_ctrl);
         end
         if (exp_valid) begin
            n_cmp++;
            if (dn_if.data !== head.data || dn_if.waddr !== head.waddr) begin
               n_err++;
               $display("FAIL random_payload[%0d]: data=%h waddr=%h required %h/%h",
                        i, dn_if.data, dn_if.waddr, head.data, head.waddr);
            end
         end
         e.ctrl  = CW'($urandom);
         e.waddr = AW'($urandom);
         e.data  = {$urandom, $urandom, $urandom};
         drive($urandom_range(0, 99) < 60, e);
         dn_if.ready = ($urandom_range(0, 99) < 55);
         flush = ($urandom_range(0, 99) < 5);
         @(posedge clk);
         acc = up_if.valid && (mq.size() < 2);
         pop = (mq.size() > 0) && dn_if.ready;
         if (flush) begin
            mq.delete();
         end else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(e);
         end
      end
      @(negedge clk);
      flush = 1'b0;
      drive(1'b0, '0);
   endtask

`ifdef MEM_WB_STATS_EN
   task automatic test_stats();
      do_reset();
      repeat (10) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (bubble_cnt !== NW'(10) || stall_cnt !== {NW{1'b0}}) begin
         n_err++;
         $display("FAIL stats_bubble: bubble=%0d stall=%0d required 10/0", bubble_cnt, stall_cnt);
      end
      drive(1'b1, mk(11'h001, DW'(96'h5)));
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, '0);
      flush = 1'b0;
      repeat ((1 << NW) + 3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (stall_cnt !== {NW{1'b1}}) begin
         n_err++;
         $display("FAIL stats_stall_sat: stall=%0d required %0d", stall_cnt, (1 << NW) - 1);
      end
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      n_cmp++;
      if (stall_cnt !== {NW{1'b1}} || bubble_cnt !== NW'(11)) begin
         n_err++;
         $display("FAIL stats_flush_keep: stall=%0d bubble=%0d required %0d/11", stall_cnt, bubble_cnt, (1 << NW) - 1);
      end
   endtask
`endif

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      flush = 1'b0;
      dn_if.ready = 1'b0;
      drive(1'b0, '0);
      test_reset();
      test_stream();
      test_full();
      test_flush();
      test_reset_mid();
      test_random(400);
`ifdef MEM_WB_STATS_EN
      test_stats();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
